// File: rtl/row_deserializer.sv
// Row deserializer: collects N = W/B bus beats into one pixel row and
// hands it to a consumer through a double-buffered valid/ready slot.
//
// Ports:
//   CLK        sole clock, all state on posedge
//   RESET_N    asynchronous active-low reset
//   BUS_VALID  beat present on BUS_DATA this cycle
//   BUS_DATA   B pixels, pixel k at [k*P +: P]
//   ROW_READY  consumer takes ROW_DATA when ROW_VALID is high
//   ROW_DATA   assembled row, pixel i = pixel (i mod B) of beat i/B
//   ROW_VALID  ROW_DATA holds an unconsumed row
//   OVERFLOW   one-cycle pulse: finished row dropped, slot was busy
//   GAP_ERROR  one-cycle pulse: partial row aborted by idle timeout
//   ROW_COUNT  rows written into ROW_DATA since reset (wraps)

package PixelSensorConfig;
    localparam int PIXEL_ARRAY_WIDTH = 4;
    localparam int OUTPUT_BUS_WIDTH  = 2;
    localparam int PIXEL_BITS        = 8;
endpackage

module row_deserializer #(
    parameter int PIXEL_ARRAY_WIDTH = PixelSensorConfig::PIXEL_ARRAY_WIDTH,
    parameter int OUTPUT_BUS_WIDTH  = PixelSensorConfig::OUTPUT_BUS_WIDTH,
    parameter int PIXEL_BITS        = PixelSensorConfig::PIXEL_BITS,
    parameter int GAP_LIMIT         = 4
) (
    input  logic                                          CLK,
    input  logic                                          RESET_N,
    input  logic                                          BUS_VALID,
    input  logic [OUTPUT_BUS_WIDTH*PIXEL_BITS-1:0]        BUS_DATA,
    input  logic                                          ROW_READY,
    output logic [PIXEL_ARRAY_WIDTH-1:0][PIXEL_BITS-1:0] ROW_DATA,
    output logic                                          ROW_VALID,
    output logic                                          OVERFLOW,
    output logic                                          GAP_ERROR,
    output logic [15:0]                                   ROW_COUNT
);

    localparam int W  = PIXEL_ARRAY_WIDTH;
    localparam int B  = OUTPUT_BUS_WIDTH;
    localparam int P  = PIXEL_BITS;
    localparam int N  = W / B;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam int GW = $clog2(GAP_LIMIT + 1);

    localparam logic [CW-1:0] LAST_BEAT = CW'(N - 1);
    localparam logic [GW-1:0] LAST_GAP  = GW'(GAP_LIMIT - 1);

    typedef enum logic {
        IDLE,
        RECEIVING
    } state_t;

    state_t                 state;
    logic [CW-1:0]          beat_cnt;
    logic [GW-1:0]          gap_cnt;
    logic [W-1:0][P-1:0]    asm_q;
    logic [W-1:0][P-1:0]    asm_next;
    logic [B-1:0][P-1:0]    beat;
    logic                   slot_free;

    assign beat = BUS_DATA;

    // Consuming and refilling may happen on the same edge.
    assign slot_free = !ROW_VALID || ROW_READY;

    // beat_cnt is 0 in IDLE, so the same merge serves the first beat.
    always_comb begin
        asm_next = asm_q;
        for (int i = 0; i < W; i++) begin
            if (i / B == int'(beat_cnt)) begin
                asm_next[i] = beat[i % B];
            end
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state     <= IDLE;
            beat_cnt  <= '0;
            gap_cnt   <= '0;
            asm_q     <= '0;
            ROW_DATA  <= '0;
            ROW_VALID <= 1'b0;
            OVERFLOW  <= 1'b0;
            GAP_ERROR <= 1'b0;
            ROW_COUNT <= '0;
        end else begin
            OVERFLOW  <= 1'b0;
            GAP_ERROR <= 1'b0;

            // A refill below overrides this drop.
            if (ROW_VALID && ROW_READY) begin
                ROW_VALID <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (BUS_VALID) begin
                        asm_q    <= asm_next;
                        beat_cnt <= CW'(1);
                        gap_cnt  <= '0;
                        state    <= RECEIVING;
                    end
                end
                RECEIVING: begin
                    if (BUS_VALID) begin
                        asm_q   <= asm_next;
                        gap_cnt <= '0;
                        if (beat_cnt == LAST_BEAT) begin
                            beat_cnt <= '0;
                            state    <= IDLE;
                            if (slot_free) begin
                                ROW_DATA  <= asm_next;
                                ROW_VALID <= 1'b1;
                                ROW_COUNT <= ROW_COUNT + 16'd1;
                            end else begin
                                OVERFLOW <= 1'b1;
                            end
                        end else begin
                            beat_cnt <= beat_cnt + CW'(1);
                        end
                    end else if (gap_cnt == LAST_GAP) begin
                        GAP_ERROR <= 1'b1;
                        state     <= IDLE;
                        beat_cnt  <= '0;
                        gap_cnt   <= '0;
                        asm_q     <= '0;
                    end else begin
                        gap_cnt <= gap_cnt + GW'(1);
                    end
                end
                default: begin
                    state    <= IDLE;
                    beat_cnt <= '0;
                    gap_cnt  <= '0;
                end
            endcase
        end
    end

endmodule

// File: doc/row_deserializer.md
ROW_DESERIALIZER -- requirements
Module: row_deserializer

Interface
REQ-001 SHALL have parameter PIXEL_ARRAY_WIDTH, default PixelSensorConfig::PIXEL_ARRAY_WIDTH, pixels per row (W).
REQ-002 SHALL have parameter OUTPUT_BUS_WIDTH, default PixelSensorConfig::OUTPUT_BUS_WIDTH, pixels per bus beat (B); W divisible by B; beats per row N = W/B >= 2.
REQ-003 SHALL have parameter PIXEL_BITS, default PixelSensorConfig::PIXEL_BITS, bits per pixel (P).
REQ-004 SHALL have parameter GAP_LIMIT, default 4, max consecutive idle cycles allowed inside a row.
REQ-005 CLK  input  1  sole clock; all state updates on posedge CLK.
REQ-006 RESET_N  input  1  reset, asynchronous and active-low.
REQ-007 BUS_VALID  input  1  high for each cycle carrying one beat from the row output buffer.
REQ-008 BUS_DATA  input  B*P  beat payload; pixel k of beat at bits [k*P +: P].
REQ-009 ROW_READY  input  1  consumer accepts ROW_DATA when high with ROW_VALID.
REQ-010 ROW_DATA  output  [W-1:0][P-1:0]  assembled row; pixel i = pixel (i mod B) of beat i/B.
REQ-011 ROW_VALID  output  1  ROW_DATA holds an unconsumed row.
REQ-012 OVERFLOW  output  1  one-cycle pulse: complete row dropped because output still held.
REQ-013 GAP_ERROR  output  1  one-cycle pulse: partial row aborted by gap timeout.
REQ-014 ROW_COUNT  output  16  rows delivered into ROW_DATA since reset, wraps 0xFFFF->0.

Function
REQ-015 SHALL assemble into an internal assembly register separate from ROW_DATA (double-buffered).
REQ-016 SHALL implement assembly FSM states IDLE and RECEIVING, plus beat counter (ceil(log2 N) bits) and gap counter.
REQ-017 IDLE: BUS_VALID high -> store beat 0, beat counter = 1, go RECEIVING; else stay.
REQ-018 RECEIVING, BUS_VALID high: store beat at index beat counter, increment counter, clear gap counter.
REQ-019 Storing beat N-1 SHALL complete the row: transfer to ROW_DATA next edge if output slot free, counter to 0, return IDLE.
REQ-020 Output slot free = ROW_VALID low, or ROW_VALID and ROW_READY high in the completing cycle (consume and refill same edge, ROW_VALID stays high).
REQ-021 Row completes with slot not free -> SHALL drop the row, leave ROW_DATA unchanged, pulse OVERFLOW, not increment ROW_COUNT.
REQ-022 ROW_VALID SHALL rise the cycle after the final beat edge (latency 1 clock from last beat sample) and fall the edge after ROW_VALID&ROW_READY with no refill.
REQ-023 ROW_DATA SHALL stay stable while ROW_VALID high and not consumed.
REQ-024 ROW_COUNT SHALL increment on each transfer into ROW_DATA.
REQ-025 RECEIVING, BUS_VALID low: increment gap counter; reaching GAP_LIMIT SHALL discard partial row, pulse GAP_ERROR, return IDLE, clear counters.
REQ-026 Beat arriving in the same cycle gap counter would reach GAP_LIMIT SHALL be accepted (no error).
REQ-027 BUS_VALID during IDLE SHALL always start a new row; ROW_READY SHALL not affect assembly.
REQ-028 OVERFLOW and GAP_ERROR SHALL never assert for more than one cycle per event.

Reset
REQ-029 RESET_N low SHALL immediately force: FSM IDLE, counters 0, ROW_VALID 0, OVERFLOW 0, GAP_ERROR 0, ROW_COUNT 0, ROW_DATA 0, assembly register 0.
REQ-030 Reset mid-row SHALL discard the partial row; first BUS_VALID after release is beat 0.
REQ-031 Reset release SHALL be synchronous-safe: no state change until first posedge CLK with RESET_N high.

Verification (W=4, B=2, P=8, GAP_LIMIT=4)
REQ-032 Beats 0x2211,0x4433 on consecutive cycles, ROW_READY=0 -> ROW_VALID=1 one cycle after beat 2, ROW_DATA pixels {0x11,0x22,0x33,0x44}, ROW_COUNT=1.
REQ-033 Second row 0x6655,0x8877 while first held, ROW_READY=0 -> OVERFLOW one-cycle pulse, ROW_DATA still {0x11..0x44}, ROW_COUNT=1.
REQ-034 Second row with ROW_READY=1 in completing cycle -> ROW_VALID stays 1, ROW_DATA {0x55,0x66,0x77,0x88}, ROW_COUNT=2.
REQ-035 Beat 0xAAAA then 4 idle cycles -> GAP_ERROR pulse on 4th idle cycle, no ROW_VALID; next beats 0x0201,0x0403 -> row {1,2,3,4}.
REQ-036 Beat 0x2211, 3 idle cycles, beat 0x4433 -> no GAP_ERROR, row {0x11,0x22,0x33,0x44}.
REQ-037 RESET_N low asynchronously after beat 0 -> all outputs 0 immediately; after release, beats 0x0605,0x0807 -> row {5,6,7,8}, ROW_COUNT=1.
